// File: rtl/keypad_scan16_if.sv
// CPU-side bus of the 4x4 keypad scanner: select/read/clear strobes in,
// last key, accumulated digit word and new-key flag out.
interface keypad_scan16_if;
   logic        cs;
   logic        rd;
   logic        clr;
   logic [3:0]  o_key;
   logic [31:0] o_data;
   logic        o_valid;

   modport master (output cs, rd, clr, input o_key, o_data, o_valid);
   modport slave  (input cs, rd, clr, output o_key, o_data, o_valid);
endinterface

// File: rtl/keypad_scan16.sv
// 4x4 keypad scanner: row drive, debounced column sampling, hex code shifted into a 32-bit digit word.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan16 #(
   parameter int SCAN_DIV_W   = 15,
   parameter int DEBOUNCE_N   = 4,
   parameter int REPEAT_TICKS = 64
) (
   input  logic           clk,
   input  logic           reset,
   keypad_scan16_if.slave bus,
   input  logic [3:0]     i_col,
   output logic [3:0]     o_row
);

   localparam logic [1:0] StScan     = 2'd0;
   localparam logic [1:0] StDebounce = 2'd1;
   localparam logic [1:0] StHeld     = 2'd2;
   localparam logic [3:0] DebN       = 4'(DEBOUNCE_N);
   localparam logic [3:0] ColIdle    = 4'b1111;

   if (DEBOUNCE_N < 1 || DEBOUNCE_N > 15 || REPEAT_TICKS < 1) begin : g_badParams
      $error("keypad_scan16: DEBOUNCE_N must be 1..15 and REPEAT_TICKS at least 1");
   end

   logic [SCAN_DIV_W-1:0] presc_q;
   logic [3:0]  colMeta_q, colS_q;
   logic [1:0]  rowIdx_q, rowIdx_d;
   logic [1:0]  state_q, state_d;
   logic [3:0]  latched_q, latched_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  relCnt_q, relCnt_d;
   logic [3:0]  key_q, key_d;
   logic [31:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        tick, singleZero, accept;
   logic [3:0]  codeSrc, code;

`ifdef KEYPAD_REPEAT_EN
   localparam int RepW = $clog2(REPEAT_TICKS + 1);
   localparam logic [RepW-1:0] RepN = RepW'(REPEAT_TICKS);
   logic [RepW-1:0] repCnt_q, repCnt_d;
`endif

   function automatic logic [1:0] zeroPos(input logic [3:0] c);
      case (c)
         4'b1101: zeroPos = 2'd1;
         4'b1011: zeroPos = 2'd2;
         4'b0111: zeroPos = 2'd3;
         default: zeroPos = 2'd0;
      endcase
   endfunction

   assign tick       = &presc_q;
   assign singleZero = (colS_q == 4'b1110) || (colS_q == 4'b1101) ||
                       (colS_q == 4'b1011) || (colS_q == 4'b0111);
   // In SCAN the code comes from the live sample; afterwards from the latched press.
   assign codeSrc    = (state_q == StScan) ? colS_q : latched_q;
   assign code       = {rowIdx_q, zeroPos(codeSrc)};
   assign o_row      = ~(4'b0001 << rowIdx_q);

   always_comb begin
      rowIdx_d  = rowIdx_q;
      state_d   = state_q;
      latched_d = latched_q;
      cnt_d     = cnt_q;
      relCnt_d  = (state_q == StHeld) ? relCnt_q : 4'd0;
      accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      repCnt_d  = (state_q == StHeld) ? repCnt_q : '0;
`endif
      if (tick) begin
         case (state_q)
            StScan: begin
               if (singleZero) begin
                  latched_d = colS_q;
                  cnt_d     = 4'd1;
                  if (DebN == 4'd1) begin
                     accept  = 1'b1;
                     state_d = StHeld;
                  end else begin
                     state_d = StDebounce;
                  end
               end else begin
                  rowIdx_d = rowIdx_q + 2'd1;
               end
            end
            StDebounce: begin
               if (colS_q == latched_q) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_d == DebN) begin
                     accept  = 1'b1;
                     state_d = StHeld;
                  end
               end else begin
                  state_d  = StScan;
                  rowIdx_d = rowIdx_q + 2'd1;
               end
            end
            StHeld: begin
               if (colS_q == ColIdle) begin
                  relCnt_d = relCnt_q + 4'd1;
                  if (relCnt_d == DebN) begin
                     state_d  = StScan;
                     rowIdx_d = rowIdx_q + 2'd1;
                  end
               end else begin
                  relCnt_d = 4'd0;
               end
`ifdef KEYPAD_REPEAT_EN
               if (colS_q == latched_q) begin
                  if (repCnt_q + 1'b1 == RepN) begin
                     accept   = 1'b1;
                     repCnt_d = '0;
                  end else begin
                     repCnt_d = repCnt_q + 1'b1;
                  end
               end
`endif
            end
            default: state_d = StScan;
         endcase
      end

      // An accept on the same edge as a strobe wins: valid stays set, clr keeps only the new digit.
      key_d   = accept ? code : key_q;
      valid_d = valid_q;
      if (bus.cs && bus.rd) valid_d = 1'b0;
      if (accept)           valid_d = 1'b1;
      data_d  = data_q;
      if (bus.cs && bus.clr) data_d = 32'd0;
      if (accept)            data_d = {data_d[27:0], code};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q   <= '0;
         colMeta_q <= 4'b1111;
         colS_q    <= 4'b1111;
         rowIdx_q  <= 2'd0;
         state_q   <= StScan;
         latched_q <= 4'b1111;
         cnt_q     <= 4'd0;
         relCnt_q  <= 4'd0;
         key_q     <= 4'd0;
         data_q    <= 32'd0;
         valid_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         repCnt_q  <= '0;
`endif
      end else begin
         presc_q   <= presc_q + SCAN_DIV_W'(1);
         colMeta_q <= i_col;
         colS_q    <= colMeta_q;
         rowIdx_q  <= rowIdx_d;
         state_q   <= state_d;
         latched_q <= latched_d;
         cnt_q     <= cnt_d;
         relCnt_q  <= relCnt_d;
         key_q     <= key_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
`ifdef KEYPAD_REPEAT_EN
         repCnt_q  <= repCnt_d;
`endif
      end
   end

   assign bus.o_key   = key_q;
   assign bus.o_data  = data_q;
   assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_keypad_scan16.sv
// Bench for keypad_scan16: a simulated key matrix, a digit-queue reference model and
// randomized key presses mixed with glitch, ghosting and bus-strobe scenarios.
module tb_keypad_scan16;

   localparam int DivW     = 2;
   localparam int DebN     = 3;
   localparam int RepTicks = 4;
   localparam int TickClks = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] iCol;
   logic [3:0] oRow;
   logic       keyDown = 1'b0;
   logic [3:0] keyCode = 4'd0;
   logic       overEn = 1'b0;
   logic [3:0] overVal = 4'b1111;
   int         edgeCnt = 0;
   int         total = 0;
   int         bad = 0;
   logic [3:0] digits[$];
   logic [3:0] lastKey = 4'd0;

   keypad_scan16_if bus();

   keypad_scan16 #(
      .SCAN_DIV_W(DivW),
      .DEBOUNCE_N(DebN),
      .REPEAT_TICKS(RepTicks)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .i_col(iCol),
      .o_row(oRow)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; scan ticks land on every TickClks-th edge.
   always @(posedge clk) edgeCnt <= reset ? edgeCnt + 1 : 0;

   // Physical matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      iCol = 4'b1111;
      if (keyDown && !oRow[keyCode[3:2]]) iCol[keyCode[1:0]] = 1'b0;
      if (overEn) iCol = overVal;
   end

   function automatic logic [31:0] packWord();
      logic [31:0] w = 32'd0;
      int n = digits.size();
      for (int i = 0; i < n; i++) w[4*(n-1-i) +: 4] = digits[i];
      return w;
   endfunction

   function automatic void acceptDigit(input logic [3:0] k);
      digits.push_back(k);
      if (digits.size() > 8) void'(digits.pop_front());
      lastKey = k;
   endfunction

   function automatic logic [3:0] rowOf(input logic [1:0] r);
      return ~(4'b0001 << r);
   endfunction

   function automatic logic [3:0] rotNext(input logic [3:0] r);
      return {r[2:0], r[3]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic nextTick();
      int guard = 0;
      do begin
         @(posedge clk); #1;
         guard++;
      end while ((edgeCnt % TickClks) != 0 && guard < 2 * TickClks);
   endtask

   task automatic pulseBus(input logic c, input logic r, input logic k);
      bus.cs = c; bus.rd = r; bus.clr = k;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0;
   endtask

   task automatic readClear(input string tag);
      pulseBus(1'b1, 1'b1, 1'b0);
      checkOutput({tag, "-rdclr"}, 32'(bus.o_valid), 32'd0);
      nextTick();
   endtask

   // Press key k (tick-aligned); strobe 1=cs&rd, 2=cs&clr on the accept edge;
   // hold holdTicks ticks after accept, then release and follow the release debounce.
   task automatic applyStimulus(input logic [3:0] k, input int strobe, input int holdTicks, input string tag);
      logic [3:0] rowBefore;
      logic [3:0] heldRow;
      bit found = 1'b0;
      heldRow = rowOf(k[3:2]);
      keyCode = k;
      keyDown = 1'b1;
      for (int i = 0; i < 8 && !found; i++) begin
         rowBefore = oRow;
         nextTick();
         if (rowBefore == heldRow) found = 1'b1;
      end
      checkOutput({tag, "-detect"}, 32'(found), 32'd1);
      if (!found) begin
         keyDown = 1'b0;
         nextTick();
         return;
      end
      nextTick();
      checkOutput({tag, "-early"}, 32'(bus.o_valid), 32'd0);
      repeat (TickClks - 1) begin @(posedge clk); #1; end
      if (strobe == 1) begin bus.cs = 1'b1; bus.rd = 1'b1; end
      if (strobe == 2) begin bus.cs = 1'b1; bus.clr = 1'b1; digits.delete(); end
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0;
      acceptDigit(k);
      checkOutput({tag, "-valid"}, 32'(bus.o_valid), 32'd1);
      checkOutput({tag, "-key"}, 32'(bus.o_key), 32'(k));
      checkOutput({tag, "-data"}, bus.o_data, packWord());
      repeat (holdTicks) nextTick();
`ifdef KEYPAD_REPEAT_EN
      for (int i = 0; i < holdTicks / RepTicks; i++) acceptDigit(k);
`endif
      keyDown = 1'b0;
      nextTick();
      nextTick();
      checkOutput({tag, "-heldrow"}, 32'(oRow), 32'(heldRow));
      nextTick();
      checkOutput({tag, "-relrow"}, 32'(oRow), 32'(rotNext(heldRow)));
      checkOutput({tag, "-reldata"}, bus.o_data, packWord());
   endtask

   initial begin
      logic [3:0] r0;
      logic [3:0] rk;
      int         sm;
      bus.cs = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0;

      // Reset and idle row rotation
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      checkOutput("rst-row", 32'(oRow), 32'h0000000E);
      checkOutput("rst-data", bus.o_data, 32'd0);
      checkOutput("rst-key", 32'(bus.o_key), 32'd0);
      checkOutput("rst-valid", 32'(bus.o_valid), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         nextTick();
         checkOutput($sformatf("scan-row%0d", i), 32'(oRow), 32'(rowOf(2'(i % 4))));
      end

      // Row 2 / column 1 key
      applyStimulus(4'h9, 0, 0, "key9");
      checkOutput("key9-word", bus.o_data, 32'h00000009);
      readClear("key9");

      // Nine keys: the oldest digit falls off the top
      pulseBus(1'b1, 1'b0, 1'b1);
      digits.delete();
      checkOutput("clr-data", bus.o_data, 32'd0);
      nextTick();
      for (int i = 1; i <= 9; i++) begin
         rk = (i == 9) ? 4'hF : 4'(i);
         applyStimulus(rk, 0, 0, $sformatf("seq%0d", i));
         readClear($sformatf("seq%0d", i));
      end
      checkOutput("seq-word", bus.o_data, 32'h2345678F);

      // Single-tick glitch is dropped, scan moves to the next row
      r0 = oRow;
      overVal = 4'b1110; overEn = 1'b1;
      nextTick();
      checkOutput("glitch-hold", 32'(oRow), 32'(r0));
      overEn = 1'b0;
      nextTick();
      checkOutput("glitch-adv", 32'(oRow), 32'(rotNext(r0)));
      checkOutput("glitch-valid", 32'(bus.o_valid), 32'd0);

      // Two columns low is ghosting: ignored, scan keeps moving
      overVal = 4'b1100; overEn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         r0 = oRow;
         nextTick();
         checkOutput($sformatf("ghost-row%0d", i), 32'(oRow), 32'(rotNext(r0)));
      end
      overEn = 1'b0;
      checkOutput("ghost-valid", 32'(bus.o_valid), 32'd0);
      checkOutput("ghost-key", 32'(bus.o_key), 32'(lastKey));
      nextTick();

      // Strobes coinciding with accepts; rd without cs
      applyStimulus(4'h3, 1, 0, "rdacc");
      pulseBus(1'b0, 1'b1, 1'b0);
      checkOutput("rd-nocs", 32'(bus.o_valid), 32'd1);
      pulseBus(1'b0, 1'b0, 1'b1);
      checkOutput("clr-nocs", bus.o_data, packWord());
      readClear("rdacc");
      applyStimulus(4'h5, 2, 0, "clracc");
      checkOutput("clracc-word", bus.o_data, 32'h00000005);
      readClear("clracc");

      // Long hold: auto-repeat only when the feature is built in
      pulseBus(1'b1, 1'b0, 1'b1);
      digits.delete();
      nextTick();
      applyStimulus(4'hA, 0, 10, "hold");
`ifdef KEYPAD_REPEAT_EN
      checkOutput("hold-word", bus.o_data, 32'h00000AAA);
`else
      checkOutput("hold-word", bus.o_data, 32'h0000000A);
`endif
      readClear("hold");

      // Randomized presses with random strobes on the accept edge
      for (int i = 0; i < 12; i++) begin
         rk = 4'($urandom_range(0, 15));
         sm = int'($urandom_range(0, 2));
         applyStimulus(rk, sm, 0, $sformatf("rnd%0d", i));
         readClear($sformatf("rnd%0d", i));
      end

      // Reset in the middle of a debounce emits nothing
      keyCode = 4'($urandom_range(0, 15));
      keyDown = 1'b1;
      repeat (5) nextTick();
      reset = 1'b0;
      keyDown = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      digits.delete();
      checkOutput("rst2-row", 32'(oRow), 32'h0000000E);
      checkOutput("rst2-key", 32'(bus.o_key), 32'd0);
      checkOutput("rst2-data", bus.o_data, 32'd0);
      repeat (6) nextTick();
      checkOutput("rst2-valid", 32'(bus.o_valid), 32'd0);
      checkOutput("rst2-word", bus.o_data, packWord());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
